// File: rtl/i2c_cond_pkg.sv
// Shared constants and types for the I2C bus conditioner.
// Default synchroniser depth, filter length, filter counter width and bus state.
package i2c_cond_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int FILT_LEN_DEF    = 3;
    localparam int CNT_W           = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } bus_state_e;

endpackage

// File: rtl/i2c_glitch_filter.sv
// One I2C line: synchroniser chain followed by a stable-count glitch filter.
// The filter is built only when I2C_GLITCH_FILTER_EN is defined; otherwise it is a plain register.
module i2c_glitch_filter
    import i2c_cond_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_LEN    = FILT_LEN_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic line_i,
    output logic line_o,
    output logic change_o
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILT_LEN < 1 || FILT_LEN > 15) begin : g_bad_param
        $error("i2c_glitch_filter: SYNC_STAGES must be 2..4 and FILT_LEN 1..15");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   filt_q, filt_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

`ifdef I2C_GLITCH_FILTER_EN
    localparam logic [CNT_W-1:0] FILT_LEN_C = CNT_W'(FILT_LEN);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt_q + CNT_W'(1);

    // NOTE: every variable gets its hold value first so no path can infer a latch.
    always_comb begin
        sync_d = sync_q;
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (ena) begin
            sync_d = {sync_q[SYNC_STAGES-2:0], line_i};
            if (synced != filt_q) begin
                if (cnt_inc == FILT_LEN_C) begin
                    filt_d = synced;
                    cnt_d  = '0;
                end else begin
                    cnt_d  = cnt_inc;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        sync_d = sync_q;
        filt_d = filt_q;
        if (ena) begin
            sync_d = {sync_q[SYNC_STAGES-2:0], line_i};
            filt_d = synced;
        end
    end
`endif

    // NOTE: state flops use non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            filt_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            filt_q <= filt_d;
        end
    end

    assign line_o   = filt_q;
    assign change_o = filt_d ^ filt_q;

endmodule

// File: rtl/i2c_bus_conditioner.sv
// I2C bus conditioner: filtered SCL/SDA, edge and START/STOP strobes, bus-busy flag.
// Filter build selected by I2C_GLITCH_FILTER_EN (undefined: no filtering, one register stage).
module i2c_bus_conditioner
    import i2c_cond_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_LEN    = FILT_LEN_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_o,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o,
    output logic busy_o
);

    logic scl_f, sda_f, scl_chg, sda_chg;

    i2c_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .line_i   (scl_i),
        .line_o   (scl_f),
        .change_o (scl_chg)
    );

    i2c_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .line_i   (sda_i),
        .line_o   (sda_f),
        .change_o (sda_chg)
    );

    logic       scl_rise_q, scl_rise_d, scl_fall_q, scl_fall_d;
    logic       start_q, start_d, stop_q, stop_d;
    bus_state_e state_q, state_d;

    // Strobes are decoded from the filters' next values so they land with the new level.
    always_comb begin
        scl_rise_d = scl_chg & ~scl_f;
        scl_fall_d = scl_chg &  scl_f;
        start_d    = sda_chg &  sda_f & scl_f & ~scl_chg;
        stop_d     = sda_chg & ~sda_f & scl_f & ~scl_chg;
        state_d    = state_q;
        if (ena) begin
            if (start_q) begin
                state_d = BUSY;
            end else if (stop_q) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            state_q    <= IDLE;
        end else begin
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            state_q    <= state_d;
        end
    end

    assign scl_o      = scl_f;
    assign sda_o      = sda_f;
    assign scl_rise_o = scl_rise_q & ena;
    assign scl_fall_o = scl_fall_q & ena;
    assign start_o    = start_q & ena;
    assign stop_o     = stop_q & ena;
    assign busy_o     = (state_q == BUSY);

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// Directed self-checking bench for i2c_bus_conditioner (SYNC_STAGES=2, FILT_LEN=3).
// Expected values follow the I2C_GLITCH_FILTER_EN build the bench is compiled with.
module tb_i2c_bus_conditioner;

    logic clk = 1'b0;
    logic rst_n, ena, scl_i, sda_i;
    logic scl_o, sda_o, scl_rise_o, scl_fall_o, start_o, stop_o, busy_o;

    always #5 clk = ~clk;

    i2c_bus_conditioner #(.SYNC_STAGES(2), .FILT_LEN(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .scl_o      (scl_o),
        .sda_o      (sda_o),
        .scl_rise_o (scl_rise_o),
        .scl_fall_o (scl_fall_o),
        .start_o    (start_o),
        .stop_o     (stop_o),
        .busy_o     (busy_o)
    );

`ifdef I2C_GLITCH_FILTER_EN
    localparam logic [7:0]  GLITCH_SDA_EXP  = 8'hFF;
    localparam logic [31:0] GLITCH_SS_EXP   = 32'd0;
    localparam logic [7:0]  START_SDA_EXP   = 8'h0F;
    localparam logic [7:0]  START_PULSE_EXP = 8'h10;
    localparam logic [7:0]  START_BUSY_EXP  = 8'hE0;
`else
    localparam logic [7:0]  GLITCH_SDA_EXP  = 8'hF3;
    localparam logic [31:0] GLITCH_SS_EXP   = 32'd1;
    localparam logic [7:0]  START_SDA_EXP   = 8'h03;
    localparam logic [7:0]  START_PULSE_EXP = 8'h04;
    localparam logic [7:0]  START_BUSY_EXP  = 8'hF8;
`endif

    int checks = 0;
    int failures = 0;

    int rise_cnt = 0, fall_cnt = 0, start_cnt = 0, stop_cnt = 0;
    int base_rise, base_fall, base_start, base_stop;
    logic prev_rise = 1'b0, prev_fall = 1'b0, prev_start = 1'b0, prev_stop = 1'b0;
    logic double_strobe = 1'b0;

    always @(posedge clk) begin
        if (scl_rise_o) rise_cnt  <= rise_cnt + 1;
        if (scl_fall_o) fall_cnt  <= fall_cnt + 1;
        if (start_o)    start_cnt <= start_cnt + 1;
        if (stop_o)     stop_cnt  <= stop_cnt + 1;
        if ((scl_rise_o && prev_rise) || (scl_fall_o && prev_fall) ||
            (start_o && prev_start) || (stop_o && prev_stop))
            double_strobe <= 1'b1;
        prev_rise  <= scl_rise_o;
        prev_fall  <= scl_fall_o;
        prev_start <= start_o;
        prev_stop  <= stop_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        base_rise  = rise_cnt;
        base_fall  = fall_cnt;
        base_start = start_cnt;
        base_stop  = stop_cnt;
    endtask

    initial begin
        logic [7:0] sda_v, start_v, busy_v;

        rst_n = 1'b0; ena = 1'b1; scl_i = 1'b1; sda_i = 1'b1;
        tick(3);
        check("reset_scl_o", 32'(scl_o), 32'd1);
        check("reset_sda_o", 32'(sda_o), 32'd1);
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_strobes", {28'd0, scl_rise_o, scl_fall_o, start_o, stop_o}, 32'd0);

        // Idle bus after reset release
        snap();
        rst_n = 1'b1;
        tick(20);
        check("idle_scl_o", 32'(scl_o), 32'd1);
        check("idle_sda_o", 32'(sda_o), 32'd1);
        check("idle_busy", 32'(busy_o), 32'd0);
        check("idle_strobes", 32'(rise_cnt + fall_cnt + start_cnt + stop_cnt - base_rise - base_fall - base_start - base_stop), 32'd0);

        // Two-cycle SDA glitch with SCL high
        snap();
        sda_i = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            sda_v[k-1] = sda_o;
            if (k == 2) sda_i = 1'b1;
        end
        tick(10);
        check("glitch_sda_trace", 32'(sda_v), 32'(GLITCH_SDA_EXP));
        check("glitch_start_cnt", 32'(start_cnt - base_start), GLITCH_SS_EXP);
        check("glitch_stop_cnt", 32'(stop_cnt - base_stop), GLITCH_SS_EXP);
        check("glitch_busy_after", 32'(busy_o), 32'd0);

        // START: SDA falls and holds while SCL high
        snap();
        sda_i = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            sda_v[k-1]   = sda_o;
            start_v[k-1] = start_o;
            busy_v[k-1]  = busy_o;
        end
        check("start_sda_trace", 32'(sda_v), 32'(START_SDA_EXP));
        check("start_pulse_trace", 32'(start_v), 32'(START_PULSE_EXP));
        check("start_busy_trace", 32'(busy_v), 32'(START_BUSY_EXP));
        check("start_cnt", 32'(start_cnt - base_start), 32'd1);

        // Eight SCL periods, SDA toggled only while SCL low
        snap();
        for (int p = 0; p < 8; p++) begin
            scl_i = 1'b0; tick(5);
            sda_i = ~sda_i; tick(5);
            scl_i = 1'b1; tick(10);
        end
        check("clk_rise_cnt", 32'(rise_cnt - base_rise), 32'd8);
        check("clk_fall_cnt", 32'(fall_cnt - base_fall), 32'd8);
        check("clk_start_cnt", 32'(start_cnt - base_start), 32'd0);
        check("clk_stop_cnt", 32'(stop_cnt - base_stop), 32'd0);
        check("clk_busy", 32'(busy_o), 32'd1);
        check("clk_lines", {30'd0, scl_o, sda_o}, 32'd2);

        // Repeated START then STOP
        snap();
        scl_i = 1'b0; tick(10);
        sda_i = 1'b1; tick(10);
        scl_i = 1'b1; tick(10);
        check("rs_setup_no_stop", 32'(stop_cnt - base_stop), 32'd0);
        sda_i = 1'b0; tick(10);
        check("rs_start_cnt", 32'(start_cnt - base_start), 32'd1);
        check("rs_busy", 32'(busy_o), 32'd1);
        scl_i = 1'b0; tick(10);
        scl_i = 1'b1; tick(10);
        sda_i = 1'b1; tick(10);
        check("stop_cnt", 32'(stop_cnt - base_stop), 32'd1);
        check("stop_busy", 32'(busy_o), 32'd0);

        // SCL and SDA change together: edge strobes only
        snap();
        scl_i = 1'b0; sda_i = 1'b0; tick(10);
        check("sim_fall_cnt", 32'(fall_cnt - base_fall), 32'd1);
        check("sim_no_start", 32'(start_cnt - base_start), 32'd0);
        check("sim_lines_low", {30'd0, scl_o, sda_o}, 32'd0);
        scl_i = 1'b1; sda_i = 1'b1; tick(10);
        check("sim_rise_cnt", 32'(rise_cnt - base_rise), 32'd1);
        check("sim_no_stop", 32'(stop_cnt - base_stop), 32'd0);
        check("sim_busy", 32'(busy_o), 32'd0);

        // Enable low freezes everything
        snap();
        ena = 1'b0; sda_i = 1'b0; tick(10);
        check("ena0_sda_o", 32'(sda_o), 32'd1);
        check("ena0_start_cnt", 32'(start_cnt - base_start), 32'd0);
        check("ena0_busy", 32'(busy_o), 32'd0);
        ena = 1'b1; tick(10);
        check("ena1_sda_o", 32'(sda_o), 32'd0);
        check("ena1_start_cnt", 32'(start_cnt - base_start), 32'd1);
        check("ena1_busy", 32'(busy_o), 32'd1);

        // Reset while busy
        snap();
        rst_n = 1'b0;
        #1;
        check("rst_busy_now", 32'(busy_o), 32'd0);
        check("rst_lines_high", {30'd0, scl_o, sda_o}, 32'd3);
        sda_i = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(20);
        check("rst_no_stop", 32'(stop_cnt - base_stop), 32'd0);
        check("rst_no_strobes", 32'(rise_cnt + fall_cnt + start_cnt - base_rise - base_fall - base_start), 32'd0);
        check("rst_busy_after", 32'(busy_o), 32'd0);

        check("no_double_strobe", 32'(double_strobe), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
